// File: rtl/appliance_pkg.sv
// Shared appliance-controller definitions: phase codes, setting width and
// the heavy-load threshold used by the washing-machine sequencer.
package appliance_pkg;

  localparam int unsigned DW         = 5;
  localparam int unsigned HEAVY_LOAD = 20;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_WASH   = 3'd1,
    PH_RINSE  = 3'd2,
    PH_SPIN   = 3'd3,
    PH_DONE   = 3'd4,
    PH_DRAIN  = 3'd5,
    PH_RINSE2 = 3'd6
  } phase_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to one-cycle duration-unit ticks.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart the count at 0 (wins over hold)
//   hold       : freeze the count
//   tick       : high while the count sits at TICK_DIV-1
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] count;

  assign tick = (count == CW'(TICK_DIV - 1));

  // Count register: clear > hold > wrap/increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!hold) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/wm_cycle_sequencer.sv
// Washing-machine cycle sequencer: runs WASH, RINSE, [RINSE2], SPIN from
// latched durations, skipping zero-length phases, with pause and abort/drain.
// Optional feature macro: WM_EXTRA_RINSE_EN adds RINSE2 for heavy loads.
// Ports:
//   clk, rst_n                       : clock, synchronous active-low reset
//   start, pause, abort              : cycle control
//   wash_time, rinse_time, spin_time : phase durations in ticks
//   cloth                            : load level, 0 = empty drum
//   phase, remaining                 : current phase code and ticks left
//   water_valve, drain_valve, motor_en : actuator enables
//   busy, done, error                : status; done/error are one-cycle pulses
module wm_cycle_sequencer #(
  parameter int unsigned TICK_DIV = 10,
  parameter int unsigned DW       = appliance_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          pause,
  input  logic          abort,
  input  logic [DW-1:0] wash_time,
  input  logic [DW-1:0] rinse_time,
  input  logic [DW-1:0] spin_time,
  input  logic [DW-1:0] cloth,
  output logic [2:0]    phase,
  output logic [DW-1:0] remaining,
  output logic          water_valve,
  output logic          drain_valve,
  output logic          motor_en,
  output logic          busy,
  output logic          done,
  output logic          error
);

  import appliance_pkg::*;

  phase_e        state, state_nxt;
  logic [DW-1:0] remaining_nxt;
  logic [DW-1:0] wash_q, rinse_q, spin_q;
  logic          heavy;
  logic          heavy_start;
  logic          accept;
  logic          tick, presc_clear, presc_hold;
  logic          frozen;
  logic          error_nxt;
  logic          water_nxt, drain_nxt, motor_nxt;

  // Position of a phase in the run order; 0 means "before the first phase"
  function automatic logic [2:0] order_of(input phase_e p);
    case (p)
      PH_WASH:   order_of = 3'd1;
      PH_RINSE:  order_of = 3'd2;
      PH_RINSE2: order_of = 3'd3;
      PH_SPIN:   order_of = 3'd4;
      default:   order_of = 3'd0;
    endcase
  endfunction

  // First phase after position 'after' with a nonzero duration, else DONE
  function automatic phase_e pick_phase(input logic [2:0] after,
                                        input logic [DW-1:0] w,
                                        input logic [DW-1:0] r,
                                        input logic [DW-1:0] s,
                                        input logic r2);
    if (after < 3'd1 && w != '0)      pick_phase = PH_WASH;
    else if (after < 3'd2 && r != '0) pick_phase = PH_RINSE;
    else if (after < 3'd3 && r2)      pick_phase = PH_RINSE2;
    else if (after < 3'd4 && s != '0) pick_phase = PH_SPIN;
    else                              pick_phase = PH_DONE;
  endfunction

  function automatic logic [DW-1:0] dur_of(input phase_e p,
                                           input logic [DW-1:0] w,
                                           input logic [DW-1:0] r,
                                           input logic [DW-1:0] s);
    case (p)
      PH_WASH:            dur_of = w;
      PH_RINSE, PH_RINSE2: dur_of = r;
      PH_SPIN:            dur_of = s;
      PH_DRAIN:           dur_of = DW'(1);
      default:            dur_of = '0;
    endcase
  endfunction

  assign accept = start && (cloth != '0);

`ifdef WM_EXTRA_RINSE_EN
  logic heavy_q;
  // RINSE2 only makes sense when there is a rinse duration to repeat
  assign heavy_start = (cloth >= DW'(HEAVY_LOAD)) && (rinse_time != '0);
  assign heavy       = heavy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      heavy_q <= 1'b0;
    end else if (state == PH_IDLE && accept) begin
      heavy_q <= heavy_start;
    end
  end
`else
  assign heavy_start = 1'b0;
  assign heavy       = 1'b0;
`endif

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (presc_clear),
    .hold  (presc_hold),
    .tick  (tick)
  );

  // Next-state, remaining and actuator decode
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    presc_clear   = 1'b0;
    presc_hold    = 1'b0;
    frozen        = 1'b0;
    error_nxt     = 1'b0;
    water_nxt     = 1'b0;
    drain_nxt     = 1'b0;
    motor_nxt     = 1'b0;

    case (state)
      PH_IDLE: begin
        presc_clear = 1'b1;
        if (start) begin
          if (cloth == '0) begin
            error_nxt = 1'b1;
          end else begin
            state_nxt     = pick_phase(3'd0, wash_time, rinse_time, spin_time,
                                       heavy_start);
            remaining_nxt = dur_of(state_nxt, wash_time, rinse_time, spin_time);
          end
        end
      end
      PH_DONE: begin
        presc_clear = 1'b1;
        state_nxt   = PH_IDLE;
      end
      PH_DRAIN: begin
        if (tick) begin
          state_nxt     = PH_IDLE;
          remaining_nxt = '0;
          presc_clear   = 1'b1;
        end
      end
      default: begin
        if (abort) begin
          state_nxt     = PH_DRAIN;
          remaining_nxt = DW'(1);
          presc_clear   = 1'b1;
        end else if (pause) begin
          presc_hold = 1'b1;
          frozen     = 1'b1;
        end else if (tick) begin
          if (remaining <= DW'(1)) begin
            state_nxt     = pick_phase(order_of(state), wash_q, rinse_q, spin_q,
                                       heavy);
            remaining_nxt = dur_of(state_nxt, wash_q, rinse_q, spin_q);
            presc_clear   = 1'b1;
          end else begin
            remaining_nxt = remaining - DW'(1);
          end
        end
      end
    endcase

    if (!frozen) begin
      water_nxt = (state_nxt == PH_WASH) || (state_nxt == PH_RINSE) ||
                  (state_nxt == PH_RINSE2);
      motor_nxt = water_nxt || (state_nxt == PH_SPIN);
      drain_nxt = (state_nxt == PH_SPIN) || (state_nxt == PH_DRAIN);
    end
  end

  // State, settings and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= PH_IDLE;
      remaining   <= '0;
      wash_q      <= '0;
      rinse_q     <= '0;
      spin_q      <= '0;
      water_valve <= 1'b0;
      drain_valve <= 1'b0;
      motor_en    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_nxt;
      remaining   <= remaining_nxt;
      water_valve <= water_nxt;
      drain_valve <= drain_nxt;
      motor_en    <= motor_nxt;
      busy        <= (state_nxt != PH_IDLE);
      done        <= (state_nxt == PH_DONE);
      error       <= error_nxt;
      if (state == PH_IDLE && accept) begin
        wash_q  <= wash_time;
        rinse_q <= rinse_time;
        spin_q  <= spin_time;
      end
    end
  end

  assign phase = 3'(state);

endmodule

// File: tb/tb_wm_cycle_sequencer.sv
// Directed plus randomized bench for wm_cycle_sequencer against a
// cycle-count reference model of the washing cycle.
module tb_wm_cycle_sequencer;

  localparam int unsigned TD = 2;
  localparam int unsigned DW = 5;

  logic          clk = 1'b0;
  logic          rst_n, start, pause, abort;
  logic [DW-1:0] wash_time, rinse_time, spin_time, cloth;
  logic [2:0]    phase;
  logic [DW-1:0] remaining;
  logic          water_valve, drain_valve, motor_en, busy, done, error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wm_cycle_sequencer #(
    .TICK_DIV (TD),
    .DW       (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pause       (pause),
    .abort       (abort),
    .wash_time   (wash_time),
    .rinse_time  (rinse_time),
    .spin_time   (spin_time),
    .cloth       (cloth),
    .phase       (phase),
    .remaining   (remaining),
    .water_valve (water_valve),
    .drain_valve (drain_valve),
    .motor_en    (motor_en),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  // Reference model: phase, clk cycles spent (unpaused) in it, its length
  int m_ph, m_cyc, m_dur;
  int m_w, m_r, m_s;
  int plan[$];
  bit m_err, m_frz;

  function automatic int m_dur_of(input int p);
    case (p)
      1:       return m_w;
      2, 6:    return m_r;
      3:       return m_s;
      5:       return 1;
      default: return 0;
    endcase
  endfunction

  task automatic m_enter_next();
    if (plan.size() > 0) m_ph = plan.pop_front();
    else                 m_ph = 4;
    m_cyc = 0;
    m_dur = m_dur_of(m_ph);
  endtask

  task automatic m_go_idle();
    m_ph  = 0;
    m_cyc = 0;
    m_dur = 0;
  endtask

  task automatic model_step();
    m_err = 1'b0;
    m_frz = 1'b0;
    if (!rst_n) begin
      m_go_idle();
      plan.delete();
      return;
    end
    case (m_ph)
      0: if (start) begin
        if (cloth == 0) begin
          m_err = 1'b1;
        end else begin
          m_w = int'(wash_time);
          m_r = int'(rinse_time);
          m_s = int'(spin_time);
          plan.delete();
          if (m_w > 0) plan.push_back(1);
          if (m_r > 0) plan.push_back(2);
`ifdef WM_EXTRA_RINSE_EN
          if (cloth >= 20 && m_r > 0) plan.push_back(6);
`endif
          if (m_s > 0) plan.push_back(3);
          m_enter_next();
        end
      end
      4: m_go_idle();
      5: begin
        m_cyc++;
        if (m_cyc == TD) m_go_idle();
      end
      default: begin
        if (abort) begin
          m_ph  = 5;
          m_cyc = 0;
          m_dur = 1;
        end else if (pause) begin
          m_frz = 1'b1;
        end else begin
          m_cyc++;
          if (m_cyc == m_dur * int'(TD)) m_enter_next();
        end
      end
    endcase
  endtask

  function automatic int m_rem();
    return m_dur - m_cyc / int'(TD);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit act, wet;
    act = (m_ph == 1 || m_ph == 2 || m_ph == 3 || m_ph == 6) && !m_frz;
    wet = (m_ph == 1 || m_ph == 2 || m_ph == 6) && !m_frz;
    chk("phase", 32'(phase), 32'(m_ph));
    chk("remaining", 32'(remaining), 32'(m_rem()));
    chk("water_valve", 32'(water_valve), 32'(wet));
    chk("motor_en", 32'(motor_en), 32'(act));
    chk("drain_valve", 32'(drain_valve),
        32'(((m_ph == 3) && !m_frz) || m_ph == 5));
    chk("busy", 32'(busy), 32'(m_ph != 0));
    chk("done", 32'(done), 32'(m_ph == 4));
    chk("error", 32'(error), 32'(m_err));
  endtask

  // Phase-change history, one nibble per phase seen
  logic [31:0] seq_code;
  logic [2:0]  last_ph;

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    if (phase != last_ph) begin
      seq_code = (seq_code << 4) | 32'(phase);
      last_ph  = phase;
    end
  endtask

  task automatic set_cfg(input int w, input int r, input int s, input int c);
    wash_time  = DW'(w);
    rinse_time = DW'(r);
    spin_time  = DW'(s);
    cloth      = DW'(c);
  endtask

  initial begin
    int done_at, idle14, wash_cnt, rinse_cnt, drain_cnt, done_cnt, found;
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    set_cfg(0, 0, 0, 0);
    seq_code = '0; last_ph = '0;
    m_go_idle(); m_w = 0; m_r = 0; m_s = 0; m_err = 0; m_frz = 0;

    // Power-on reset
    step(); step();
    rst_n = 1'b1;
    step();

    // Normal cycle: WASH 1-4, RINSE 5-6, SPIN 7-12, DONE 13, IDLE 14
    set_cfg(2, 1, 3, 5);
    start = 1'b1; step(); start = 1'b0;
    done_at = -1; idle14 = -1;
    for (int i = 2; i <= 16; i++) begin
      step();
      if (done && done_at < 0) done_at = i;
      if (i == 14) idle14 = int'(phase);
    end
    chk("normal_done_cycle", 32'(done_at), 32'd13);
    chk("normal_idle_at_14", 32'(idle14), 32'd0);

    // Empty drum rejected
    set_cfg(2, 2, 2, 0);
    start = 1'b1; step(); start = 1'b0;
    chk("empty_error", 32'(error), 32'd1);
    step(); step();
    chk("empty_phase", 32'(phase), 32'd0);

    // Skip zero rinse, pause 5 cycles in WASH
    set_cfg(2, 0, 1, 3);
    wash_cnt = 0; rinse_cnt = 0;
    start = 1'b1; step(); start = 1'b0;
    if (phase == 3'd1) wash_cnt++;
    step(); if (phase == 3'd1) wash_cnt++;
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (phase == 3'd1) wash_cnt++;
    end
    chk("pause_motor_off", 32'(motor_en), 32'd0);
    pause = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (phase == 3'd1) wash_cnt++;
      if (phase == 3'd2) rinse_cnt++;
    end
    chk("pause_wash_len", 32'(wash_cnt), 32'd9);
    chk("skip_rinse", 32'(rinse_cnt), 32'd0);

    // Reset mid-WASH
    set_cfg(3, 1, 1, 7);
    start = 1'b1; step(); start = 1'b0;
    step();
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();

    // Abort in SPIN with two ticks left
    set_cfg(1, 0, 3, 4);
    start = 1'b1; step(); start = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (m_ph == 3 && m_rem() == 2) found = 1;
      else step();
    end
    chk("abort_reached_spin", 32'(found), 32'd1);
    drain_cnt = 0; done_cnt = 0;
    abort = 1'b1; step(); abort = 1'b0;
    if (phase == 3'd5 && drain_valve) drain_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (phase == 3'd5 && drain_valve) drain_cnt++;
      if (done) done_cnt++;
    end
    chk("abort_drain_len", 32'(drain_cnt), 32'd2);
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    // Abort together with pause
    set_cfg(3, 1, 1, 6);
    start = 1'b1; step(); start = 1'b0;
    step();
    pause = 1'b1; abort = 1'b1; step();
    chk("abort_pause_drain", 32'(phase), 32'd5);
    pause = 1'b0; abort = 1'b0;
    step(); step(); step();

    // Heavy load phase sequence
    set_cfg(1, 1, 1, 25);
    seq_code = '0; last_ph = phase;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 14; i++) step();
`ifdef WM_EXTRA_RINSE_EN
    chk("heavy_sequence", seq_code, 32'h0012_6340);
`else
    chk("heavy_sequence", seq_code, 32'h0001_2340);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      start = ($urandom_range(0, 5) == 0);
      pause = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0)
        set_cfg(31, int'($urandom_range(0, 1)), 1, 9);
      else
        set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 25)));
      step();
    end
    rst_n = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wm_cycle_sequencer.md
# wm_cycle_sequencer

Sequences one washing machine through its wash, rinse and spin phases from the 5-bit duration settings that the appliance controller already carries. It counts minutes off a prescaled clock and drives the water valve, drain valve and motor enables for the drum. It also reports the current phase and the remaining minutes. One instance sits beside each washing-machine channel in the top-level appliance controller.

## Interface
- TICK_DIV, 10: clk cycles per duration unit ("minute"); ≥2.
- DW, 5: width of the duration and load settings.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a cycle; sampled only in IDLE.
- pause  in  1  level; freezes the active phase while high.
- abort  in  1  cancel the cycle; drain, then return to IDLE.
- wash_time, rinse_time, spin_time  in  DW  phase durations in ticks; latched on an accepted start.
- cloth  in  DW  load level; 0 means an empty drum; latched on an accepted start.
- phase  out  3  IDLE=0, WASH=1, RINSE=2, SPIN=3, DONE=4, DRAIN=5, RINSE2=6.
- remaining  out  DW  ticks left in the current phase.
- water_valve, drain_valve, motor_en  out  1  actuator enables.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a cycle completes normally.
- error  out  1  one-cycle pulse when a start is rejected.

## Operation
- Reset: state IDLE; every output 0; the prescaler, the latched settings and `remaining` are cleared.
- Outputs are Moore-decoded from the state register, except `done` and `error`, which are registered pulses.
- Actuator decode:
  - WASH and RINSE/RINSE2: water_valve=1, motor_en=1.
  - SPIN: motor_en=1, drain_valve=1.
  - DRAIN: drain_valve=1.
  - All other states drive the actuators to 0.
- Start in IDLE with cloth≠0:
  - Latch all settings.
  - Enter the first phase in the order WASH, RINSE, [RINSE2], SPIN whose duration is nonzero.
  - If every duration is 0, go directly to DONE.
- Start in IDLE with cloth=0: `error` pulses on the next cycle and the state stays IDLE.
- Start outside IDLE is ignored.
- On phase entry, load `remaining` with the phase duration and clear the prescaler.
- Prescaler: counts 0..TICK_DIV-1 and raises `tick` at TICK_DIV-1.
- On each tick, `remaining` decrements. A tick with remaining=1 moves to the next nonzero phase, or to DONE if none is left. Zero-duration phases are skipped in the same transition.
- DONE lasts 1 cycle with `done`=1, then returns to IDLE.
- Pause: high in WASH, RINSE, RINSE2 or SPIN freezes the prescaler and `remaining`, forces all actuators to 0, and leaves `phase` unchanged. Pause is ignored in IDLE, DONE and DRAIN.
- Abort:
  - In WASH, RINSE, RINSE2 or SPIN (paused or not): enter DRAIN with remaining=1 and the prescaler cleared.
  - DRAIN lasts one tick, then goes to IDLE with no `done` pulse.
  - Abort is ignored in IDLE, DONE and DRAIN.
- Priority: reset > abort > pause > tick.
- Arithmetic: `remaining` never wraps. A duration of 31 gives 31·TICK_DIV cycles.

## Timing
- An accepted start sampled at edge k gives the first phase visible from cycle k+1.
- A phase of duration N occupies exactly N·TICK_DIV cycles plus any paused cycles.
- `error` is asserted in cycle k+1 after a rejected start at edge k.
- `done` is asserted in the single DONE cycle; IDLE follows on the next cycle.
- Abort sampled at edge k gives DRAIN from cycle k+1 for TICK_DIV cycles.
- Reset asserted mid-cycle: all outputs are 0 on the cycle after the sampling edge.

## Configuration
- WM_EXTRA_RINSE_EN defined:
  - Latching a start with cloth ≥ 20 enables RINSE2, a second rinse of rinse_time ticks between RINSE and SPIN.
  - RINSE2 is skipped when rinse_time=0.
- WM_EXTRA_RINSE_EN undefined: RINSE2 is never entered and phase code 6 never appears.

## Structure
- Shared package `appliance_pkg`: the phase enum (3-bit codes above), DW, and the heavy-load threshold constant HEAVY_LOAD=20.
- One sub-module, `tick_prescaler`, holds the TICK_DIV counter with clear and hold inputs and a `tick` output.
- The phase-selection function that skips zero-duration phases lives in the sequencer.

## Test plan
Benches use TICK_DIV=2 and cycle numbers count from the start edge (cycle 0).
- Reset: rst_n=0 for 2 cycles mid-WASH → phase=0, busy=0, remaining=0, all actuators 0.
- Normal cycle: wash=2, rinse=1, spin=3, cloth=5, start at cycle 0 → WASH cycles 1–4, RINSE 5–6, SPIN 7–12, done=1 at cycle 13, IDLE at 14.
- Empty drum: cloth=0, start → error=1 for one cycle, phase stays 0, done never asserted.
- Skip and pause: wash=2, rinse=0, spin=1; pause held 5 cycles during WASH → remaining frozen, motor_en=0, WASH lasts 9 cycles, then SPIN directly, no RINSE.
- Abort: abort during SPIN with remaining=2 → DRAIN for 2 cycles with drain_valve=1, then IDLE, no done; abort together with pause → DRAIN.
- Heavy load: with WM_EXTRA_RINSE_EN, cloth=25, rinse=1 → phase sequence 1, 2, 6, 3, 4; without the macro, the sequence is 1, 2, 3, 4.
